pmod_ledctrl: RTL
=================

// Module: pmod_ledctrl
//
// PURPOSE
//  Owner of the PMod LED8 pins. Takes the free-running Knight-Rider pattern
//  from the LED bouncer on i_bounce and lets the ZipCPU override it over a
//  Wishbone slave port.
//  A CPU write to the LED register takes control. Control returns to the
//  bouncer when a programmable inactivity timeout expires, or on command.
//  Sits between the bouncer and the output pins. It is the last register
//  before the pads.
//
// PARAMETERS
//  NLEDS       8            LED count; 1..16 (2*NLEDS <= 32)
//  TOBITS      26           timeout counter width; 1..30
//  DEFAULT_TO  26'h2000000  timeout reload value after reset; 0 = never
//
// PORTS
//  i_clk       in   1       system clock
//  i_reset     in   1       synchronous, active-high reset
//  i_wb_cyc    in   1       Wishbone cycle
//  i_wb_stb    in   1       Wishbone strobe
//  i_wb_we     in   1       1 = write
//  i_wb_addr   in   1       0 = LEDS register, 1 = CTRL register
//  i_wb_data   in   32      write data
//  o_wb_stall  out  1       constant 0
//  o_wb_ack    out  1       acknowledge, one cycle after strobe
//  o_wb_data   out  32      read data, valid with o_wb_ack
//  i_bounce    in   NLEDS   pattern from the LED bouncer
//  o_led       out  NLEDS   registered PMod LED drive
//  o_int       out  1       1-cycle pulse on timeout revert
//
// BEHAVIOUR
//  Reset values: mode=BOUNCE, cpu_led=0, to_val=DEFAULT_TO, ctr=0.
//  All outputs are 0 during reset: o_led, o_wb_ack, o_wb_data, o_int.
//
//  Bus
//  - Strobe qualifier: stb = i_wb_cyc & i_wb_stb. The port never stalls.
//  - o_wb_ack <= stb, so the ack arrives 1 cycle after the strobe.
//  - o_wb_data is registered on every stb and is 0 otherwise.
//  - Pipelined back-to-back strobes are accepted, one per clock.
//
//  Register map
//  - LEDS write (addr 0): mask m = d[2N-1:N], value v = d[N-1:0].
//    - For each k with m[k]=1: cpu_led[k] <= v[k].
//    - If m==0, cpu_led <= v.
//    - Every LEDS write also sets mode=CPU and sets ctr <= to_val.
//  - LEDS read: {zeros, cpu_led, o_led}, with cpu_led in [2N-1:N].
//  - CTRL write (addr 1), d[31]=1:
//    - mode <= BOUNCE, ctr <= 0.
//    - to_val is unchanged and o_int is not pulsed.
//  - CTRL write (addr 1), d[31]=0:
//    - to_val <= d[TOBITS-1:0].
//    - If mode==CPU, ctr <= d[TOBITS-1:0].
//  - CTRL read: {mode(1=CPU) at bit 31, zeros, to_val}.
//
//  Mode FSM
//  - BOUNCE -> CPU on any LEDS write.
//  - CPU -> BOUNCE on a CTRL force write.
//  - CPU -> BOUNCE on expiry:
//    - Condition: mode==CPU, ctr==1 and no LEDS write this cycle.
//    - Next cycle: mode=BOUNCE, ctr=0, o_int=1 for exactly 1 cycle.
//  - Countdown: in CPU mode ctr decrements when nonzero. ctr==0 in CPU
//    mode means no timeout (to_val==0).
//  - A LEDS write on the expiry cycle wins: mode stays CPU, ctr is
//    reloaded, no o_int.
//  - While in BOUNCE mode, ctr is held at 0.
//
//  Output
//  - o_led <= (mode==CPU) ? cpu_led : i_bounce, registered with 1-cycle
//    latency.
//  - After a LEDS write strobe at cycle t, o_led shows the new value at t+2.
//  - i_bounce is assumed synchronous to i_clk; no synchroniser is used.
//
//  Reset mid-operation
//  - Abandons any CPU override and restores to_val=DEFAULT_TO.
//  - An outstanding ack is dropped.
//
// TESTING
//  1. Reset, i_bounce=8'h18 held.
//     -> o_led=0 during reset; o_led=8'h18 on the first clock after release.
//  2. Write addr0 = 32'h0000_FFA5.
//     -> ack at t+1; o_led=8'hA5 at t+2; CTRL reads bit31=1.
//  3. Then write addr0 = 32'h0000_0F00.
//     -> cpu_led=8'hA0; LEDS reads 32'h0000_A0A0 once settled.
//  4. Write CTRL=10, then LEDS=32'h0000_FF55.
//     -> mode reverts exactly 10 cycles after the LEDS write;
//     -> o_int high for exactly 1 cycle;
//     -> o_led tracks i_bounce the cycle after.
//  5. CTRL=3; LEDS write, then a second LEDS write on the ctr==1 cycle.
//     -> no revert and no o_int; revert 3 cycles after the second write.
//  6. CPU mode with CTRL=0.
//     -> no revert after 1000 cycles.
//     -> CTRL write 32'h8000_0000: BOUNCE next cycle, o_int stays 0.
//     -> i_reset asserted mid-override: mode=BOUNCE, CTRL reads DEFAULT_TO.

Source files
------------

// File: rtl/pmod_ledctrl.sv
// pmod_ledctrl: final register stage in front of the PMod LED8 pads.
// The LED pins normally follow the free-running bouncer pattern. A CPU write
// to the LEDS register takes over the pins until an inactivity timeout
// expires or the CPU hands control back through the CTRL register.
module pmod_ledctrl #(
    parameter int                NLEDS      = 8,
    parameter int                TOBITS     = 26,
    parameter logic [TOBITS-1:0] DEFAULT_TO = TOBITS'(26'h2000000)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    // Wishbone slave (pipelined, never stalls)
    input  logic             i_wb_cyc,
    input  logic             i_wb_stb,
    input  logic             i_wb_we,
    input  logic             i_wb_addr,
    input  logic [31:0]      i_wb_data,
    output logic             o_wb_stall,
    output logic             o_wb_ack,
    output logic [31:0]      o_wb_data,
    // LED path
    input  logic [NLEDS-1:0] i_bounce,
    output logic [NLEDS-1:0] o_led,
    output logic             o_int
);

    // Who owns the pins: the bouncer, or the CPU override.
    typedef enum logic {
        MODE_BOUNCE = 1'b0,
        MODE_CPU    = 1'b1
    } mode_t;

    localparam logic [TOBITS-1:0] CTR_ONE = TOBITS'(1);

    mode_t             mode;
    logic [NLEDS-1:0]  cpu_led;
    logic [TOBITS-1:0] to_val;
    logic [TOBITS-1:0] ctr;

    logic              stb;
    logic              leds_wr;
    logic              ctrl_wr;
    logic              ctrl_force;
    logic [NLEDS-1:0]  wr_mask;
    logic [NLEDS-1:0]  wr_val;
    logic [TOBITS-1:0] wr_to;
    logic [NLEDS-1:0]  led_merged;
    logic [31:0]       rd_data;
    logic              unused_data;

    // Bus decode; every strobe is accepted on the cycle it is presented.
    assign stb        = i_wb_cyc & i_wb_stb;
    assign leds_wr    = stb & i_wb_we & ~i_wb_addr;
    assign ctrl_wr    = stb & i_wb_we &  i_wb_addr;
    assign ctrl_force = i_wb_data[31];
    assign wr_mask    = i_wb_data[2*NLEDS-1:NLEDS];
    assign wr_val     = i_wb_data[NLEDS-1:0];
    assign wr_to      = i_wb_data[TOBITS-1:0];
    assign o_wb_stall = 1'b0;

    // Not every data bit is meaningful for every parameter set.
    assign unused_data = ^i_wb_data;

    // Masked LED update: an all-zero mask means "write every LED".
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch can never be inferred.
        led_merged = wr_val;
        if (wr_mask != '0) begin
            led_merged = (cpu_led & ~wr_mask) | (wr_val & wr_mask);
        end
    end

    // Read mux: LEDS returns {cpu_led, o_led}; CTRL returns {mode, to_val}.
    always_comb begin
        rd_data = '0;
        if (i_wb_addr) begin
            rd_data[31]         = (mode == MODE_CPU);
            rd_data[TOBITS-1:0] = to_val;
        end else begin
            rd_data[2*NLEDS-1:0] = {cpu_led, o_led};
        end
    end

    // Ownership FSM with inactivity countdown and revert interrupt.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge value of every other register.
        if (i_reset) begin
            mode    <= MODE_BOUNCE;
            cpu_led <= '0;
            to_val  <= DEFAULT_TO;
            ctr     <= '0;
            o_int   <= 1'b0;
        end else begin
            o_int <= 1'b0;
            if (leds_wr) begin
                // A LEDS write always wins, including on the expiry cycle.
                cpu_led <= led_merged;
                mode    <= MODE_CPU;
                ctr     <= to_val;
            end else if (ctrl_wr && ctrl_force) begin
                // Handing back on command is silent: no interrupt.
                mode <= MODE_BOUNCE;
                ctr  <= '0;
            end else if (ctrl_wr) begin
                // A new timeout restarts a running override immediately.
                to_val <= wr_to;
                if (mode == MODE_CPU) begin
                    ctr <= wr_to;
                end
            end else if (mode == MODE_CPU) begin
                if (ctr == CTR_ONE) begin
                    mode  <= MODE_BOUNCE;
                    ctr   <= '0;
                    o_int <= 1'b1;
                end else if (ctr != '0) begin
                    ctr <= ctr - CTR_ONE;
                end
            end else begin
                ctr <= '0;
            end
        end
    end

    // Bus response: ack and read data one cycle after each strobe.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_wb_ack  <= 1'b0;
            o_wb_data <= '0;
        end else begin
            o_wb_ack  <= stb;
            o_wb_data <= stb ? rd_data : '0;
        end
    end

    // Pad register: the selected source, one cycle behind the mode.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_led <= '0;
        end else begin
            o_led <= (mode == MODE_CPU) ? cpu_led : i_bounce;
        end
    end

endmodule
